// File: rtl/dmadd_sequencer_if.sv
// Signal bundle between host, dmadd_sequencer and the multiply-add core pins.
// slave is the sequencer's view; master is the host/core side.
interface dmadd_sequencer_if #(
  parameter int NSLOTS = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [4*NSLOTS-1:0]   s_data;
  logic [NSLOTS-1:0]     s_mask;
  logic [1:0]            s_insn;
  logic                  mac_load;
  logic [3:0]            mac_index;
  logic [3:0]            mac_data;
  logic                  mac_run;
  logic [1:0]            mac_insn;
  logic [11:0]           mac_out;
  logic                  r_valid;
  logic                  r_ready;
  logic [11:0]           r_data;

  modport slave (
    input  s_valid, s_data, s_mask, s_insn, mac_out, r_ready,
    output s_ready, mac_load, mac_index, mac_data, mac_run, mac_insn, r_valid, r_data
  );

  modport master (
    output s_valid, s_data, s_mask, s_insn, mac_out, r_ready,
    input  s_ready, mac_load, mac_index, mac_data, mac_run, mac_insn, r_valid, r_data
  );
endinterface

// File: rtl/dmadd_sequencer.sv
// Host-side sequencer for the nibble-serial multiply-add core: serialises a masked operand
// set into slot writes, strobes run, waits RESULT_LAT cycles and returns the captured result.
//
// state | meaning
// IDLE  | ready for a new operand set
// LOAD  | one slot write per set mask bit, ascending slot order
// RUN   | single run strobe carrying the instruction
// WAIT  | down-counting the core result latency
// RESP  | result presented until the consumer takes it
module dmadd_sequencer #(
  parameter int NSLOTS     = 16,
  parameter int RESULT_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dmadd_sequencer_if.slave bus,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, RESP} state_t;

  state_t              state, state_d;
  logic [4*NSLOTS-1:0] data_q, data_d, data_src;
  logic [NSLOTS-1:0]   mask_q, mask_d, mask_src, mask_rest;
  logic [1:0]          insn_q, insn_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                load_q, load_d;
  logic                run_q, run_d;
  logic [3:0]          index_q, index_d;
  logic [3:0]          nib_q, nib_d;
  logic [1:0]          minsn_q, minsn_d;
  logic [11:0]         rdata_q, rdata_d;
  logic [3:0]          first_idx, first_nib;

  // In IDLE the first slot is picked straight off the stream so the first write lands at T0+1.
  assign data_src = (state == IDLE) ? bus.s_data : data_q;
  assign mask_src = (state == IDLE) ? bus.s_mask : mask_q;

  always_comb begin
    first_idx = '0;
    first_nib = '0;
    mask_rest = mask_src;
    for (int k = NSLOTS - 1; k >= 0; k--) begin
      if (mask_src[k]) begin
        first_idx = 4'(k);
        first_nib = data_src[4*k +: 4];
      end
    end
    for (int k = 0; k < NSLOTS; k++) begin
      if (4'(k) == first_idx) mask_rest[k] = 1'b0;
    end
  end

  always_comb begin
    state_d = state;
    data_d  = data_q;
    mask_d  = mask_q;
    insn_d  = insn_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    index_d = '0;
    nib_d   = '0;
    run_d   = 1'b0;
    minsn_d = '0;
    rdata_d = rdata_q;
    case (state)
      IDLE: begin
        if (bus.s_valid) begin
          data_d = bus.s_data;
          mask_d = mask_rest;
          insn_d = bus.s_insn;
          if (|bus.s_mask) begin
            state_d = LOAD;
            load_d  = 1'b1;
            index_d = first_idx;
            nib_d   = first_nib;
          end else begin
            state_d = RUN;
            run_d   = 1'b1;
            minsn_d = bus.s_insn;
          end
        end
      end
      LOAD: begin
        if (|mask_q) begin
          load_d  = 1'b1;
          index_d = first_idx;
          nib_d   = first_nib;
          mask_d  = mask_rest;
        end else begin
          state_d = RUN;
          run_d   = 1'b1;
          minsn_d = insn_q;
        end
      end
      RUN: begin
        state_d = WAIT;
        cnt_d   = 4'(RESULT_LAT);
        minsn_d = insn_q;
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          rdata_d = bus.mac_out;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          minsn_d = insn_q;
        end
      end
      RESP: begin
        if (bus.r_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      insn_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      index_q <= '0;
      nib_q   <= '0;
      run_q   <= 1'b0;
      minsn_q <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      insn_q  <= insn_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      index_q <= index_d;
      nib_q   <= nib_d;
      run_q   <= run_d;
      minsn_q <= minsn_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.s_ready   = (state == IDLE);
  assign bus.r_valid   = (state == RESP);
  assign busy          = (state != IDLE);
  assign bus.mac_load  = load_q;
  assign bus.mac_index = index_q;
  assign bus.mac_data  = nib_q;
  assign bus.mac_run   = run_q;
  assign bus.mac_insn  = minsn_q;
  assign bus.r_data    = rdata_q;

endmodule

// File: tb/tb_dmadd_sequencer.sv
`timescale 1ns/1ps
// Bench for dmadd_sequencer: expected core/response events are queued when a set is driven
// and matched against what a negedge monitor observes; hand sequences cover the corners.
module tb_dmadd_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, busy1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   loads_seen = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmadd_sequencer_if #(.NSLOTS(16)) bus ();
  dmadd_sequencer_if #(.NSLOTS(1))  bus1 ();

  dmadd_sequencer #(.NSLOTS(16), .RESULT_LAT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );
  dmadd_sequencer #(.NSLOTS(1), .RESULT_LAT(1)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1)
  );

  // Core result changes every cycle so an off-by-one capture shows up.
  function automatic logic [11:0] core_val(input int c);
    return 12'((c * 37 + 11) ^ (c >> 3));
  endfunction
  function automatic logic [11:0] core_val1(input int c);
    return 12'((c * 53) ^ 32'h5A5);
  endfunction

  assign bus.mac_out  = core_val(cyc);
  assign bus1.mac_out = core_val1(cyc);

  typedef struct {
    int kind;
    int cyc;
    int a;
    int b;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [15:0] mask;
    logic [63:0] data;
    logic [1:0]  insn;
    int          n_loads;
    int          run_ofs;
    int          rv_ofs;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic observe(input int kind, input int a, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: actual kind %0d a %0h b %0h at cycle %0d, required none",
               kind, a, b, cyc);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind%0d", e.kind),
            {8'h0, 4'(kind), 20'(cyc), 16'(a), 16'(b)},
            {8'h0, 4'(e.kind), 20'(e.cyc), 16'(e.a), 16'(e.b)});
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      if (bus.mac_load === 1'b1) begin
        loads_seen++;
        observe(0, int'(bus.mac_index), int'(bus.mac_data));
      end else begin
        check("idle_index_data", 64'({bus.mac_index, bus.mac_data}), 64'd0);
      end
      if (bus.mac_run === 1'b1) observe(1, int'(bus.mac_insn), 0);
      if (busy === 1'b0) check("idle_insn", 64'(bus.mac_insn), 64'd0);
      if (bus.r_valid === 1'b1 && bus.r_ready === 1'b1) observe(2, int'(bus.r_data), 0);
    end
  end

  task automatic send(input logic [15:0] m, input logic [63:0] d, input logic [1:0] ins,
                      input int run_ofs, input int rv_ofs);
    int guard = 0;
    int j = 0;
    int a;
    bus.s_valid = 1'b1;
    bus.s_mask  = m;
    bus.s_data  = d;
    bus.s_insn  = ins;
    while (bus.s_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 64'(bus.s_ready), 64'd1);
    a = cyc;
    for (int k = 0; k < 16; k++) begin
      if (m[k]) begin
        j++;
        exp_q.push_back('{0, a + j, k, int'(d[4*k +: 4])});
      end
    end
    exp_q.push_back('{1, a + run_ofs, int'(ins), 0});
    exp_q.push_back('{2, a + rv_ofs, int'(core_val(a + rv_ofs - 1)), 0});
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || bus.s_ready !== 1'b1) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int          a;
    int          guard;
    logic [11:0] bp_val;
    logic [12:0] small_exp[1:5];

    vecs[0] = '{16'hFFFF, 64'h0123456789ABCDEF, 2'b01, 16, 17, 22};
    vecs[1] = '{16'h8101, 64'hFEDCBA9876543210, 2'b10,  3,  4,  9};
    vecs[2] = '{16'h0000, 64'h1111111111111111, 2'b11,  0,  1,  6};
    vecs[3] = '{16'h0001, 64'h0000000000000005, 2'b00,  1,  2,  7};
    vecs[4] = '{16'h8000, 64'h7000000000000000, 2'b11,  1,  2,  7};
    vecs[5] = '{16'hAAAA, 64'h13579BDF02468ACE, 2'b10,  8,  9, 14};

    small_exp[1] = {1'b1, 4'h0, 4'hA, 1'b0, 2'b00, 1'b0};
    small_exp[2] = {1'b0, 4'h0, 4'h0, 1'b1, 2'b10, 1'b0};
    small_exp[3] = {1'b0, 4'h0, 4'h0, 1'b0, 2'b10, 1'b0};
    small_exp[4] = {1'b0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b1};
    small_exp[5] = {1'b0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0};

    rst_n        = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_mask   = '0;
    bus.s_data   = '0;
    bus.s_insn   = '0;
    bus.r_ready  = 1'b1;
    bus1.s_valid = 1'b0;
    bus1.s_mask  = '0;
    bus1.s_data  = '0;
    bus1.s_insn  = '0;
    bus1.r_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_s_ready", 64'(bus.s_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_strobes", 64'({bus.mac_load, bus.mac_run, bus.r_valid}), 64'd0);
    check("reset_mac_fields", 64'({bus.mac_index, bus.mac_data, bus.mac_insn}), 64'd0);
    check("reset_r_data", 64'(bus.r_data), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      loads_seen = 0;
      send(vecs[i].mask, vecs[i].data, vecs[i].insn, vecs[i].run_ofs, vecs[i].rv_ofs);
      wait_done($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_loads", i), 64'(loads_seen), 64'(vecs[i].n_loads));
    end

    // Response backpressure with a second set held on the stream the whole time.
    bus.r_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_mask  = 16'h0003;
    bus.s_data  = 64'h00000000000000C5;
    bus.s_insn  = 2'b10;
    check("bp_accept_ready", 64'(bus.s_ready), 64'd1);
    a = cyc;
    exp_q.push_back('{0, a + 1, 0, 5});
    exp_q.push_back('{0, a + 2, 1, 12});
    exp_q.push_back('{1, a + 3, 2, 0});
    bp_val = core_val(a + 7);
    @(negedge clk);
    bus.s_mask = 16'h0010;
    bus.s_data = 64'h0000000000090000;
    bus.s_insn = 2'b11;
    guard = 0;
    while (bus.r_valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_rvalid_cycle", 64'(cyc), 64'(a + 8));
    for (int i = 0; i < 10; i++) begin
      check("bp_rdata_hold", 64'(bus.r_data), 64'(bp_val));
      check("bp_rvalid_hold", 64'(bus.r_valid), 64'd1);
      check("bp_s_ready_low", 64'(bus.s_ready), 64'd0);
      @(negedge clk);
    end
    bus.r_ready = 1'b1;
    exp_q.push_back('{2, cyc, int'(bp_val), 0});
    @(negedge clk);
    check("bp_next_accept_ready", 64'(bus.s_ready), 64'd1);
    a = cyc;
    exp_q.push_back('{0, a + 1, 4, 9});
    exp_q.push_back('{1, a + 2, 3, 0});
    exp_q.push_back('{2, a + 7, int'(core_val(a + 6)), 0});
    @(negedge clk);
    bus.s_valid = 1'b0;
    wait_done("bp_drain");

    // Reset pulse while slot 5 is being written.
    bus.s_valid = 1'b1;
    bus.s_mask  = 16'hFFFF;
    bus.s_data  = 64'hFEDCBA9876543210;
    bus.s_insn  = 2'b01;
    a = cyc;
    for (int k = 0; k < 6; k++) exp_q.push_back('{0, a + 1 + k, k, k});
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_at_index5", 64'(bus.mac_index), 64'd5);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_load_low", 64'(bus.mac_load), 64'd0);
    check("rst_busy_low", 64'(busy), 64'd0);
    check("rst_rvalid_low", 64'(bus.r_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", 64'(bus.s_ready), 64'd1);
    repeat (30) @(negedge clk);
    check("rst_no_pending", 64'(exp_q.size()), 64'd0);

    // NSLOTS = 1, RESULT_LAT = 1 instance.
    bus1.s_valid = 1'b1;
    bus1.s_mask  = 1'b1;
    bus1.s_data  = 4'hA;
    bus1.s_insn  = 2'b10;
    check("small_accept_ready", 64'(bus1.s_ready), 64'd1);
    a = cyc;
    @(negedge clk);
    bus1.s_valid = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      check($sformatf("small_t%0d", t),
            64'({bus1.mac_load, bus1.mac_index, bus1.mac_data, bus1.mac_run,
                 bus1.mac_insn, bus1.r_valid}),
            64'(small_exp[t]));
      if (t == 4) check("small_rdata", 64'(bus1.r_data), 64'(core_val1(a + 3)));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmadd_sequencer.md
Name: dmadd_sequencer

Overview:
- Host-side initiator for the nibble-serial multiply-add core.
- Accepts one full operand set plus an instruction over a valid/ready stream and serialises the operands into per-slot load writes (index + 4-bit data).
- Issues a one-cycle run strobe with the instruction, waits a fixed result latency, then captures the 12-bit result and returns it over a valid/ready response stream.
- Sits between a test/host controller and the core's load/run/insn/index/data/out pins.

Parameters:
- NSLOTS, 16, number of 4-bit operand slots; legal range 1..16; sets the s_data/s_mask widths.
- RESULT_LAT, 4, cycles from the run strobe to a valid core result; legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- s_valid  input  1  operand set offered
- s_ready  output  1  sequencer idle and able to accept
- s_data  input  4*NSLOTS  slot k nibble = s_data[4k+3:4k]
- s_mask  input  NSLOTS  bit k = 1: write slot k; 0: skip slot k
- s_insn  input  2  instruction for this operation
- mac_load  output  1  slot write strobe to core
- mac_index  output  4  slot address
- mac_data  output  4  slot nibble
- mac_run  output  1  start strobe to core
- mac_insn  output  2  instruction to core
- mac_out  input  12  core result
- r_valid  output  1  result available
- r_ready  input  1  result consumer ready
- r_data  output  12  captured result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous active-low and sampled on the rising edge.
- Reset state: state = IDLE. mac_load, mac_run, r_valid and busy are 0. mac_index, mac_data, mac_insn and r_data are 0. s_ready is a combinational decode of state == IDLE, so it is 1 once reset has been applied.
- State machine: IDLE -> LOAD -> RUN -> WAIT -> RESP -> IDLE.
- IDLE:
  - s_ready = 1.
  - The accept edge T0 is the edge where s_valid && s_ready.
  - At T0, latch s_data, s_mask and s_insn, then go to LOAD. If the mask is all zero, go directly to RUN.
- LOAD:
  - One cycle per set mask bit, in ascending slot order. Cleared slots consume zero cycles.
  - Each LOAD cycle drives mac_load = 1, mac_index = k, and mac_data = latched nibble k.
  - After the last set bit, go to RUN.
- RUN:
  - Exactly one cycle, with mac_run = 1, mac_load = 0, and mac_insn = latched insn.
  - Go to WAIT and load the counter with RESULT_LAT.
- WAIT:
  - The counter decrements once per cycle.
  - On the edge where the counter reaches 0 (RESULT_LAT cycles after the RUN cycle), capture mac_out into r_data and go to RESP.
- RESP:
  - r_valid = 1. r_data is held stable until the handshake.
  - On r_valid && r_ready, go to IDLE.
  - With r_ready tied high, r_valid is a single-cycle pulse.
- Timing, with P = popcount(mask):
  - LOAD cycles are T0+1 .. T0+P.
  - RUN cycle is T0+P+1.
  - mac_out is sampled at the end of cycle T0+P+1+RESULT_LAT.
  - r_valid is high from cycle T0+P+2+RESULT_LAT.
- Output hold rules:
  - mac_insn holds the latched insn through RUN and WAIT, and is 0 in IDLE.
  - mac_index and mac_data are 0 whenever mac_load = 0.
  - All mac_* outputs are registered.
- s_valid while busy: ignored. No latch takes place and no state changes.
- Back-to-back operation: the earliest next accept is the cycle after the RESP handshake. There is no overlap between a response and a new load.
- Reset mid-operation: aborts immediately. All outputs return to reset values on that edge, no partial result is delivered, and no mac_run is issued for the aborted set.

Test Plan:
- Full mask, back-to-back data:
  - Stimulus: NSLOTS = 16, RESULT_LAT = 4, mask = 16'hFFFF, s_data = 64'h0123456789ABCDEF, insn = 2'b01.
  - Required: mac_load high for cycles T0+1..T0+16 with index 0..15 and data F,E,D,...,0; mac_run high only at T0+17 with mac_insn = 01; r_valid at T0+22 with r_data = mac_out sampled at end of T0+21.
- Sparse mask:
  - Stimulus: mask = 16'h8101.
  - Required: exactly three load cycles with index 0, 8, 15; run at T0+4; r_valid at T0+9.
- Zero mask:
  - Stimulus: mask = 0.
  - Required: no mac_load; mac_run at T0+1; r_valid at T0+6.
- Response backpressure:
  - Stimulus: hold r_ready = 0 for 10 cycles after r_valid rises, while driving s_valid continuously.
  - Required: r_data stable; s_ready = 0 throughout; after r_ready = 1, exactly one response, and the new set is accepted on the following edge.
- Mid-operation reset:
  - Stimulus: rst_n = 0 for one cycle at LOAD index 5.
  - Required: on that edge mac_load = 0 and busy = 0; no mac_run and no r_valid afterwards; s_ready = 1 the next cycle.
- Parameter corner:
  - Stimulus: NSLOTS = 1, RESULT_LAT = 1, mask = 1, data = 4'hA.
  - Required: a single load (index 0, data A) at T0+1; run at T0+2; r_valid at T0+4.
